// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        FS_REQ,
        FS_HOLD,
        FS_DRAIN
    } fetch_state_t;

    localparam int unsigned PC_STEP    = 4;
    localparam int unsigned PERF_CNT_W = 16;

endpackage

// File: rtl/fetch_sequencer_adder.sv
// Plain WIDTH-bit adder; the carry out is dropped so sums wrap modulo 2^WIDTH.
module fetch_sequencer_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/fetch_sequencer.sv
// Single-outstanding-request fetch sequencer with redirect/drain handling.
// Optional decode stall counter enabled by defining FETCH_PERF_CNT_EN.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned IWIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  redirect,
    input  logic [WIDTH-1:0]      redirect_pc,
    output logic                  imem_req,
    output logic [WIDTH-1:0]      imem_addr,
    input  logic                  imem_ack,
    input  logic [IWIDTH-1:0]     imem_rdata,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [IWIDTH-1:0]     inst,
    output logic [WIDTH-1:0]      inst_pc,
    output logic [WIDTH-1:0]      inst_pc_plus4
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [PERF_CNT_W-1:0] stall_cycles
`endif
);

    localparam logic [WIDTH-1:0] STEP = WIDTH'(PC_STEP);

    fetch_state_t      state_q, state_d;
    logic [WIDTH-1:0]  pc_q, pc_d;
    logic [WIDTH-1:0]  req_addr_q, req_addr_d;
    logic [IWIDTH-1:0] inst_q, inst_d;
    logic [WIDTH-1:0]  inst_pc_q, inst_pc_d;
    logic [WIDTH-1:0]  req_addr_plus4;

    // The successor is taken from the acked address, so the pc reset value of 4
    // and a redirect target both yield the correct next fetch.
    fetch_sequencer_adder #(
        .WIDTH(WIDTH)
    ) u_next_pc_adder (
        .a  (req_addr_q),
        .b  (STEP),
        .sum(req_addr_plus4)
    );

    fetch_sequencer_adder #(
        .WIDTH(WIDTH)
    ) u_inst_pc_adder (
        .a  (inst_pc_q),
        .b  (STEP),
        .sum(inst_pc_plus4)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= FS_REQ;
            pc_q       <= STEP;
            req_addr_q <= '0;
            inst_q     <= '0;
            inst_pc_q  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            inst_q     <= inst_d;
            inst_pc_q  <= inst_pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        inst_d     = inst_q;
        inst_pc_d  = inst_pc_q;
        case (state_q)
            FS_REQ: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                    if (imem_ack) begin
                        req_addr_d = redirect_pc;
                    end else begin
                        state_d = FS_DRAIN;
                    end
                end else if (imem_ack) begin
                    inst_d    = imem_rdata;
                    inst_pc_d = req_addr_q;
                    pc_d      = req_addr_plus4;
                    state_d   = FS_HOLD;
                end
            end
            FS_HOLD: begin
                if (redirect) begin
                    pc_d       = redirect_pc;
                    req_addr_d = redirect_pc;
                    state_d    = FS_REQ;
                end else if (inst_ready) begin
                    req_addr_d = pc_q;
                    state_d    = FS_REQ;
                end
            end
            FS_DRAIN: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                end
                if (imem_ack) begin
                    req_addr_d = redirect ? redirect_pc : pc_q;
                    state_d    = FS_REQ;
                end
            end
            default: state_d = FS_REQ;
        endcase
    end

    assign imem_req   = (state_q != FS_HOLD);
    assign imem_addr  = req_addr_q;
    assign inst_valid = (state_q == FS_HOLD);
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;

`ifdef FETCH_PERF_CNT_EN
    logic [PERF_CNT_W-1:0] stall_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_q <= '0;
        end else if (state_q == FS_HOLD && !inst_ready && !redirect && stall_q != '1) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: acked addresses and delivered
// instructions are queued by the stimulus and popped by a negedge monitor.
module tb_fetch_sequencer;

    typedef struct packed {
        logic [31:0] inst;
        logic [7:0]  pc;
        logic [7:0]  pc4;
    } exp_inst_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        redirect = 1'b0;
    logic [7:0]  redirect_pc = '0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [7:0]  inst_pc;
    logic [7:0]  inst_pc_plus4;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] stall_cycles;
`endif

    int unsigned nvec = 0;
    int unsigned nerr = 0;
    logic        prev_valid = 1'b0;
    logic [7:0]  exp_addr_q[$];
    exp_inst_t   exp_inst_q[$];

    fetch_sequencer #(
        .WIDTH (8),
        .IWIDTH(32)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .inst         (inst),
        .inst_pc      (inst_pc),
        .inst_pc_plus4(inst_pc_plus4)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic ack_with(input logic [31:0] data);
        imem_ack   = 1'b1;
        imem_rdata = data;
        step();
        imem_ack   = 1'b0;
    endtask

    // Monitor: a handshake is judged at the negedge before the edge that takes it.
    always @(negedge clock) begin
        if (reset) begin
            prev_valid = 1'b0;
        end else begin
            if (imem_req && imem_ack) begin
                if (exp_addr_q.size() == 0) begin
                    check("unexpected_ack_addr", 32'(imem_addr), 32'hFFFF_FFFF);
                end else begin
                    check("ack_addr", 32'(imem_addr), 32'(exp_addr_q.pop_front()));
                end
            end
            if (inst_valid && !prev_valid) begin
                if (exp_inst_q.size() == 0) begin
                    check("unexpected_inst", inst, 32'hFFFF_FFFF);
                end else begin
                    exp_inst_t e;
                    e = exp_inst_q.pop_front();
                    check("inst", inst, e.inst);
                    check("inst_pc", 32'(inst_pc), 32'(e.pc));
                    check("inst_pc_plus4", 32'(inst_pc_plus4), 32'(e.pc4));
                end
            end
            prev_valid = inst_valid;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) step();
        reset = 1'b0;
        check("rst_req", 32'(imem_req), 32'd1);
        check("rst_addr", 32'(imem_addr), 32'h00);
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_pc_plus4", 32'(inst_pc_plus4), 32'h04);
`ifdef FETCH_PERF_CNT_EN
        check("rst_stall", 32'(stall_cycles), 32'd0);
`endif

        // First fetch acked after two idle cycles.
        step();
        step();
        exp_addr_q.push_back(8'h00);
        exp_inst_q.push_back('{inst: 32'hA1, pc: 8'h00, pc4: 8'h04});
        ack_with(32'hA1);
        check("hold_valid", 32'(inst_valid), 32'd1);
        check("hold_req", 32'(imem_req), 32'd0);

        // Back-pressure for five cycles; a stray ack in HOLD must be ignored.
        imem_ack   = 1'b1;
        imem_rdata = 32'hFF;
        step();
        imem_ack = 1'b0;
        repeat (4) step();
        check("stall_inst", inst, 32'hA1);
        check("stall_inst_pc", 32'(inst_pc), 32'h00);
        check("stall_valid", 32'(inst_valid), 32'd1);
`ifdef FETCH_PERF_CNT_EN
        check("stall_cycles", 32'(stall_cycles), 32'd5);
`endif
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        check("next_addr", 32'(imem_addr), 32'h04);
        check("next_valid", 32'(inst_valid), 32'd0);

        // Redirect while awaiting ack: drain the request at 4, then fetch 0x40.
        redirect    = 1'b1;
        redirect_pc = 8'h40;
        step();
        redirect = 1'b0;
        check("drain_req", 32'(imem_req), 32'd1);
        check("drain_addr", 32'(imem_addr), 32'h04);
        exp_addr_q.push_back(8'h04);
        ack_with(32'hDEAD);
        check("drain_valid", 32'(inst_valid), 32'd0);
        check("drain_next_addr", 32'(imem_addr), 32'h40);
        exp_addr_q.push_back(8'h40);
        exp_inst_q.push_back('{inst: 32'hB2, pc: 8'h40, pc4: 8'h44});
        ack_with(32'hB2);

        // Redirect beats inst_ready in HOLD.
        redirect    = 1'b1;
        redirect_pc = 8'h20;
        inst_ready  = 1'b1;
        step();
        redirect   = 1'b0;
        inst_ready = 1'b0;
        check("hold_redir_valid", 32'(inst_valid), 32'd0);
        check("hold_redir_addr", 32'(imem_addr), 32'h20);

        // Redirect with ack in FS_REQ discards data and refetches at target.
        exp_addr_q.push_back(8'h20);
        redirect    = 1'b1;
        redirect_pc = 8'hFC;
        ack_with(32'hEE);
        redirect = 1'b0;
        check("req_redir_valid", 32'(inst_valid), 32'd0);
        check("req_redir_addr", 32'(imem_addr), 32'hFC);

        // Fetch at 0xFC: pc+4 wraps to 0.
        exp_addr_q.push_back(8'hFC);
        exp_inst_q.push_back('{inst: 32'hC3, pc: 8'hFC, pc4: 8'h00});
        ack_with(32'hC3);
        check("wrap_pc_plus4", 32'(inst_pc_plus4), 32'h00);
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        check("wrap_next_addr", 32'(imem_addr), 32'h00);

        // Reset while draining.
        redirect    = 1'b1;
        redirect_pc = 8'h80;
        step();
        redirect = 1'b0;
        reset    = 1'b1;
        step();
        reset = 1'b0;
        check("drain_rst_addr", 32'(imem_addr), 32'h00);
        check("drain_rst_valid", 32'(inst_valid), 32'd0);
        check("drain_rst_req", 32'(imem_req), 32'd1);
`ifdef FETCH_PERF_CNT_EN
        check("drain_rst_stall", 32'(stall_cycles), 32'd0);
`endif
        exp_addr_q.push_back(8'h00);
        exp_inst_q.push_back('{inst: 32'hD4, pc: 8'h00, pc4: 8'h04});
        ack_with(32'hD4);
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        check("post_rst_addr", 32'(imem_addr), 32'h04);

        // Two redirects in drain, the second coinciding with the ack.
        redirect    = 1'b1;
        redirect_pc = 8'h60;
        step();
        redirect_pc = 8'h70;
        exp_addr_q.push_back(8'h04);
        ack_with(32'h99);
        redirect = 1'b0;
        check("drain_last_redir_addr", 32'(imem_addr), 32'h70);
        check("drain_last_redir_valid", 32'(inst_valid), 32'd0);
        exp_addr_q.push_back(8'h70);
        exp_inst_q.push_back('{inst: 32'hE5, pc: 8'h70, pc4: 8'h74});
        ack_with(32'hE5);
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        check("final_addr", 32'(imem_addr), 32'h74);

        step();
        check("addr_queue_drained", 32'(exp_addr_q.size()), 32'd0);
        check("inst_queue_drained", 32'(exp_inst_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 8, PC and address width in bits.
REQ-002 The block SHALL provide parameter IWIDTH, default 32, instruction width in bits.
REQ-003 The block SHALL provide the following ports (clock and reset first):
- clock  input  1  single clock, all state on rising edge.
- reset  input  1  synchronous, active-high.
- redirect  input  1  branch-taken/redirect request from execute.
- redirect_pc  input  WIDTH  redirect target.
- imem_req  output  1  instruction memory request.
- imem_addr  output  WIDTH  request address.
- imem_ack  input  1  single-cycle completion strobe; imem_rdata valid when high.
- imem_rdata  input  IWIDTH  fetched instruction.
- inst_valid  output  1  instruction available to decode.
- inst_ready  input  1  decode accepts the instruction.
- inst  output  IWIDTH  held instruction.
- inst_pc  output  WIDTH  address of the held instruction.
- inst_pc_plus4  output  WIDTH  inst_pc + 4.
- stall_cycles  output  16  decode back-pressure cycle count; present only with FETCH_PERF_CNT_EN.

Function
REQ-004 The block SHALL implement states FS_REQ, FS_HOLD and FS_DRAIN.
REQ-005 The block SHALL keep a next-fetch register pc and a request-address register req_addr; imem_addr SHALL equal req_addr.
REQ-006 In FS_REQ and FS_DRAIN, imem_req SHALL be 1; in FS_HOLD it SHALL be 0. imem_addr SHALL remain stable while imem_req=1 until imem_ack.
REQ-007 FS_REQ with imem_ack=1 and redirect=0 SHALL capture inst<=imem_rdata and inst_pc<=req_addr, set pc<=pc+4, and go to FS_HOLD.
REQ-008 FS_REQ with redirect=1 and imem_ack=1 SHALL discard imem_rdata, set pc<=redirect_pc and req_addr<=redirect_pc, and stay in FS_REQ.
REQ-009 FS_REQ with redirect=1 and imem_ack=0 SHALL set pc<=redirect_pc, leave req_addr unchanged, and go to FS_DRAIN.
REQ-010 In FS_HOLD, inst_valid SHALL be 1; in every other state it SHALL be 0.
REQ-011 FS_HOLD with redirect=1 SHALL drop the held instruction, set pc<=redirect_pc and req_addr<=redirect_pc, and go to FS_REQ; redirect SHALL take priority over inst_ready.
REQ-012 FS_HOLD with inst_ready=1 and redirect=0 SHALL set req_addr<=pc and go to FS_REQ.
REQ-013 FS_DRAIN SHALL discard the data from the outstanding request; on imem_ack it SHALL set req_addr<=pc and go to FS_REQ.
REQ-014 A redirect in FS_DRAIN SHALL overwrite pc, with the last redirect winning; this includes a redirect in the same cycle as imem_ack, which also sets req_addr<=redirect_pc.
REQ-015 inst, inst_pc and inst_pc_plus4 SHALL hold their values while inst_valid=1.
REQ-016 pc+4 and inst_pc+4 SHALL wrap modulo 2^WIDTH.
REQ-017 Minimum latency SHALL be one cycle from imem_ack to inst_valid, and one cycle from handshake to the next imem_req.
REQ-018 imem_ack while imem_req=0 SHALL be ignored.

Reset
REQ-019 When reset=1 at a rising edge, the block SHALL set state<=FS_REQ, pc<=4, req_addr<=0, inst<=0 and inst_pc<=0.
REQ-020 The first cycle after reset SHALL therefore present imem_req=1, imem_addr=0, inst_valid=0 and inst_pc_plus4=4.
REQ-021 Reset SHALL override all other inputs, including mid-request and mid-drain; any outstanding memory ack after reset SHALL be treated per REQ-007 at address 0.

Configuration
REQ-022 When FETCH_PERF_CNT_EN is defined, port stall_cycles SHALL exist and SHALL increment in each cycle with state=FS_HOLD and inst_ready=0 and redirect=0.
REQ-023 stall_cycles SHALL saturate at 16'hFFFF and SHALL reset to 0.
REQ-024 When FETCH_PERF_CNT_EN is undefined, the port and the counter logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-025 Shared package fetch_pkg SHALL contain: enum fetch_state_t {FS_REQ, FS_HOLD, FS_DRAIN}, constant PC_STEP=4 and constant PERF_CNT_W=16.
REQ-026 The PC increment SHALL use the codebase's existing adder module, parameterised to WIDTH, as the single sub-module.

Verification
REQ-027 The bench SHALL cover: reset, then imem_ack after 2 cycles with rdata=32'hA1 -> inst_valid=1, inst=32'hA1, inst_pc=0, inst_pc_plus4=4, next imem_addr=4 after inst_ready.
REQ-028 The bench SHALL cover: FS_HOLD with inst_ready=0 for 5 cycles -> inst stable and, with the macro, stall_cycles=5.
REQ-029 The bench SHALL cover: redirect with redirect_pc=8'h40 while FS_REQ awaits ack -> FS_DRAIN; ack rdata is discarded, inst_valid stays 0, next imem_addr=8'h40.
REQ-030 The bench SHALL cover: redirect and inst_ready together in FS_HOLD with redirect_pc=8'h20 -> instruction dropped, imem_addr=8'h20.
REQ-031 The bench SHALL cover: pc=8'hFC fetched -> inst_pc_plus4=8'h00 and next imem_addr=8'h00.
REQ-032 The bench SHALL cover: reset asserted during FS_DRAIN -> next cycle imem_addr=0, inst_valid=0, stall_cycles=0.
